// File: rtl/sym_deser_pkg.sv
// sym_deser_pkg: shared types and sizing helpers for the symbol deserializer.
// Revision 1.0
`default_nettype none

package sym_deser_pkg;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } obuf_state_t;

   function automatic int word_w(input int sym_w, input int nsym);
      return sym_w * nsym;
   endfunction

   function automatic int cnt_w(input int nsym);
      return $clog2(nsym);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sym_deser_obuf.sv
// sym_deser_obuf: registered word output with valid/ready handshake; optional parity
// bit under SYM_DESER_PARITY_EN. Revision 1.0
`default_nettype none

module sym_deser_obuf
   import sym_deser_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] din,
`ifdef SYM_DESER_PARITY_EN
   input  logic              din_parity,
   output logic              parity,
`endif
   input  logic              out_ready,
   output logic [WORD_W-1:0] dout,
   output logic              valid
);

   obuf_state_t state;
   logic        take;

   // The parent never asserts load while full and stalled, so a load is always taken.
   assign take  = load && ((state == EMPTY) || out_ready);
   assign valid = (state == FULL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= EMPTY;
         dout   <= '0;
`ifdef SYM_DESER_PARITY_EN
         parity <= 1'b0;
`endif
      end else begin
         if (take) begin
            dout   <= din;
`ifdef SYM_DESER_PARITY_EN
            parity <= din_parity;
`endif
         end
         if (state == EMPTY) begin
            if (load)
               state <= FULL;
         end else begin
            if (out_ready && !load)
               state <= EMPTY;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sym_deserializer.sv
// sym_deserializer: packs SYM_W-bit symbols (first symbol in LSBs) into NSYM-symbol words
// with backpressure; optional O_parity output under SYM_DESER_PARITY_EN. Revision 1.0
`default_nettype none

module sym_deserializer
   import sym_deser_pkg::*;
#(
   parameter int SYM_W = 2,
   parameter int NSYM  = 4
) (
   input  logic                             CLK,
   input  logic                             ASYNCRESET,
   input  logic [SYM_W-1:0]                 I,
   input  logic                             I_valid,
   output logic                             I_ready,
   output logic [word_w(SYM_W, NSYM)-1:0]   O,
   output logic                             O_valid,
`ifdef SYM_DESER_PARITY_EN
   output logic                             O_parity,
`endif
   input  logic                             O_ready
);

   localparam int WORD_W = word_w(SYM_W, NSYM);
   localparam int CNT_W  = cnt_w(NSYM);
   localparam int ACC_W  = WORD_W - SYM_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSYM - 1);

   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;
   logic              last;
   logic              accept;
   logic [WORD_W-1:0] word;

   assign last    = (cnt == LAST);
   assign I_ready = !(last && O_valid && !O_ready);
   assign accept  = I_valid && I_ready;
   // The final symbol goes straight to the output, so the accumulator omits its slot.
   assign word    = {I, acc};

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         if (last) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
            acc[cnt*SYM_W +: SYM_W] <= I;
         end
      end
   end

`ifdef SYM_DESER_PARITY_EN
   logic word_parity;
   assign word_parity = ^word;
`endif

   sym_deser_obuf #(
      .WORD_W     (WORD_W)
   ) u_obuf (
      .clk        (CLK),
      .rst        (ASYNCRESET),
      .load       (accept && last),
      .din        (word),
`ifdef SYM_DESER_PARITY_EN
      .din_parity (word_parity),
      .parity     (O_parity),
`endif
      .out_ready  (O_ready),
      .dout       (O),
      .valid      (O_valid)
   );

endmodule

`default_nettype wire
